// File: rtl/alu_result_serializer_if.sv
// Bus bundle between the ALU result stage, the serializer and the UART TX front-end.
// The master modport is the serializer's view (it drives the TX byte stream);
// the slave modport is the surrounding environment's view.
interface alu_result_serializer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
);
   logic [DATA_WIDTH-1:0] alu_out;
   logic [DATA_WIDTH-1:0] alu_carry;
   logic                  alu_valid;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  busy;
   logic                  drop_pulse;
   logic [CNT_WIDTH-1:0]  word_cnt;

   modport master (
      input  alu_out, alu_carry, alu_valid, tx_ready,
      output tx_data, tx_valid, busy, drop_pulse, word_cnt
   );

   modport slave (
      output alu_out, alu_carry, alu_valid, tx_ready,
      input  tx_data, tx_valid, busy, drop_pulse, word_cnt
   );
endinterface

// File: rtl/alu_result_serializer.sv
// Splits each 2*DATA_WIDTH ALU result into two TX bytes (low first) and
// streams them over a valid/ready handshake, with a one-word pending buffer.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | nothing in flight, tx_valid low, pending buffer empty
// SEND_LO | low byte of holder presented on tx_data
// SEND_HI | high byte of holder presented on tx_data
module alu_result_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input logic clk,
   input logic rst,
   alu_result_serializer_if.master bus
);
   localparam int RW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_LO = 2'd1,
      SEND_HI = 2'd2
   } state_t;

   state_t         state;
   logic [RW-1:0]  holder;
   logic [RW-1:0]  pend_data;
   logic           pend_full;
   logic           valid_d;

   logic [RW-1:0]  alu_word;
   logic           result_event;
   logic           xfer;

   // Rising edge of the level-type result flag; a held flag yields one event.
   assign alu_word     = {bus.alu_carry, bus.alu_out};
   assign result_event = bus.alu_valid & ~valid_d;
   assign xfer         = bus.tx_valid & bus.tx_ready;

   // Serializer FSM with pending buffer; all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         holder         <= '0;
         pend_data      <= '0;
         pend_full      <= 1'b0;
         valid_d        <= 1'b0;
         bus.tx_data    <= '0;
         bus.tx_valid   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.drop_pulse <= 1'b0;
         bus.word_cnt   <= '0;
      end else begin
         valid_d        <= bus.alu_valid;
         bus.drop_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (result_event) begin
                  holder       <= alu_word;
                  bus.tx_data  <= bus.alu_out;
                  bus.tx_valid <= 1'b1;
                  bus.busy     <= 1'b1;
                  state        <= SEND_LO;
               end else begin
                  bus.busy     <= 1'b0;
               end
            end
            SEND_LO: begin
               bus.busy <= 1'b1;
               if (xfer) begin
                  bus.tx_data <= holder[RW-1:DATA_WIDTH];
                  state       <= SEND_HI;
               end
               if (result_event) begin
                  if (!pend_full) begin
                     pend_data <= alu_word;
                     pend_full <= 1'b1;
                  end else begin
                     bus.drop_pulse <= 1'b1;
                  end
               end
            end
            SEND_HI: begin
               if (xfer) begin
                  bus.word_cnt <= bus.word_cnt + CNT_WIDTH'(1);
                  if (pend_full) begin
                     // Pending word goes out next; a coincident event refills pending.
                     holder      <= pend_data;
                     bus.tx_data <= pend_data[DATA_WIDTH-1:0];
                     bus.busy    <= 1'b1;
                     state       <= SEND_LO;
                     if (result_event) pend_data <= alu_word;
                     else              pend_full <= 1'b0;
                  end else if (result_event) begin
                     holder      <= alu_word;
                     bus.tx_data <= bus.alu_out;
                     bus.busy    <= 1'b1;
                     state       <= SEND_LO;
                  end else begin
                     bus.tx_valid <= 1'b0;
                     bus.busy     <= 1'b0;
                     state        <= IDLE;
                  end
               end else begin
                  bus.busy <= 1'b1;
                  if (result_event) begin
                     if (!pend_full) begin
                        pend_data <= alu_word;
                        pend_full <= 1'b1;
                     end else begin
                        bus.drop_pulse <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state        <= IDLE;
               bus.tx_valid <= 1'b0;
               bus.busy     <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_alu_result_serializer;
   logic clk = 1'b0;
   logic rst;

   alu_result_serializer_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

   alu_result_serializer #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int checks_total  = 0;
   int checks_passed = 0;

   // Reference model: words accepted but not fully sent, in arrival order.
   logic [15:0] words[$];
   bit          hi_sent_lo;
   bit          prev_valid;
   bit          exp_drop;
   logic [7:0]  exp_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      words.delete();
      hi_sent_lo = 1'b0;
      prev_valid = 1'b0;
      exp_drop   = 1'b0;
      exp_cnt    = 8'd0;
   endtask

   // One clock: drive inputs, advance model at the edge, compare just after it.
   task automatic step(input bit r, input bit v, input logic [7:0] carry,
                       input logic [7:0] low, input bit rdy);
      bit xfer;
      bit ev;
      rst           = r;
      bus.alu_valid = v;
      bus.alu_carry = carry;
      bus.alu_out   = low;
      bus.tx_ready  = rdy;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         xfer       = (words.size() > 0) && rdy;
         ev         = v && !prev_valid;
         prev_valid = v;
         exp_drop   = 1'b0;
         if (xfer) begin
            if (hi_sent_lo) begin
               void'(words.pop_front());
               hi_sent_lo = 1'b0;
               exp_cnt    = exp_cnt + 8'd1;
            end else begin
               hi_sent_lo = 1'b1;
            end
         end
         if (ev) begin
            if (words.size() < 2) words.push_back({carry, low});
            else                  exp_drop = 1'b1;
         end
      end
      #1;
      chk("tx_valid", 32'(bus.tx_valid), 32'(words.size() > 0));
      if (words.size() > 0)
         chk("tx_data", 32'(bus.tx_data),
             32'(hi_sent_lo ? words[0][15:8] : words[0][7:0]));
      if (r) chk("tx_data_rst", 32'(bus.tx_data), 32'd0);
      chk("busy", 32'(bus.busy), 32'(words.size() > 0));
      chk("drop_pulse", 32'(bus.drop_pulse), 32'(exp_drop));
      chk("word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));
   endtask

   initial begin
      logic [7:0] rc, rl;
      model_reset();
      rst = 1'b1;
      bus.alu_valid = 1'b0;
      bus.alu_carry = '0;
      bus.alu_out   = '0;
      bus.tx_ready  = 1'b0;

      // Reset then single result
      step(1, 0, 8'h00, 8'h00, 1);
      step(1, 0, 8'h00, 8'h00, 1);
      step(0, 1, 8'h01, 8'h2C, 1);
      chk("s1_lo_byte", 32'(bus.tx_data), 32'h2C);
      step(0, 0, 8'h00, 8'h00, 1);
      chk("s1_hi_byte", 32'(bus.tx_data), 32'h01);
      step(0, 0, 8'h00, 8'h00, 1);
      step(0, 0, 8'h00, 8'h00, 1);
      chk("s1_word_cnt", 32'(bus.word_cnt), 32'd1);
      chk("s1_busy", 32'(bus.busy), 32'd0);

      // Backpressure
      step(1, 0, 8'h00, 8'h00, 0);
      step(0, 1, 8'hAB, 8'hCD, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 8'h00, 8'h00, 0);
         chk("s2_hold_data", 32'(bus.tx_data), 32'hCD);
      end
      step(0, 0, 8'h00, 8'h00, 1);
      chk("s2_hi_byte", 32'(bus.tx_data), 32'hAB);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00, 1);
      chk("s2_word_cnt", 32'(bus.word_cnt), 32'd1);

      // Level flag held high with changing data
      step(1, 0, 8'h00, 8'h00, 1);
      for (int i = 0; i < 20; i++)
         step(0, 1, 8'($urandom), 8'($urandom), 1);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h00, 1);
      chk("s3_word_cnt", 32'(bus.word_cnt), 32'd1);

      // Pending and drop
      step(1, 0, 8'h00, 8'h00, 0);
      step(0, 1, 8'h01, 8'h02, 0);
      step(0, 0, 8'h00, 8'h00, 0);
      step(0, 1, 8'h03, 8'h04, 0);
      step(0, 0, 8'h00, 8'h00, 0);
      step(0, 1, 8'h05, 8'h06, 0);
      chk("s4_drop", 32'(bus.drop_pulse), 32'd1);
      step(0, 0, 8'h00, 8'h00, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 8'h00, 1);
      chk("s4_word_cnt", 32'(bus.word_cnt), 32'd2);

      // Event coincident with high-byte transfer
      step(1, 0, 8'h00, 8'h00, 1);
      step(0, 1, 8'h11, 8'h22, 1);
      step(0, 0, 8'h00, 8'h00, 1);
      step(0, 1, 8'h77, 8'h88, 1);
      chk("s5_next_lo", 32'(bus.tx_data), 32'h88);
      step(0, 0, 8'h00, 8'h00, 1);
      chk("s5_next_hi", 32'(bus.tx_data), 32'h77);
      step(0, 0, 8'h00, 8'h00, 1);
      step(0, 0, 8'h00, 8'h00, 1);
      chk("s5_word_cnt", 32'(bus.word_cnt), 32'd2);

      // Reset mid-word
      step(1, 0, 8'h00, 8'h00, 1);
      step(0, 1, 8'h55, 8'h66, 1);
      step(0, 0, 8'h00, 8'h00, 1);
      step(1, 0, 8'h00, 8'h00, 1);
      chk("s6_valid_after_rst", 32'(bus.tx_valid), 32'd0);
      step(0, 1, 8'h9A, 8'hBC, 1);
      chk("s6_new_lo", 32'(bus.tx_data), 32'hBC);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h00, 1);
      chk("s6_word_cnt", 32'(bus.word_cnt), 32'd1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rc = 8'($urandom);
         rl = 8'($urandom);
         step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, rc, rl,
              $urandom_range(0, 9) < 7);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
